i2c_bus_arbiter: RTL and testbench

// Shares one i2c_master between NUM_REQ requesters (e.g. left/right ranging sensors, IMU)

---
 rtl/i2c_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one i2c_master between NUM_REQ requesters, with
// NACK retry, stuck-transaction timeout/master reset, and per-requester acks.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int MAX_BYTES      = 3,
    parameter int MAX_RETRIES    = 2,
    parameter int RETRY_GAP      = 1250,
    parameter int TIMEOUT_CYCLES = 200000,
    localparam int BN_W = $clog2(MAX_BYTES + 1),
    localparam int GW   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_rd_nwr,
    input  logic [NUM_REQ*7-1:0]        req_addr,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_din,
    input  logic [NUM_REQ*BN_W-1:0]     req_nbytes,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [MAX_BYTES*8-1:0]      resp_data,
    output logic [1:0]                  resp_status,
    output logic                        busy,
    output logic [GW-1:0]               grant_idx,
    output logic                        m_start,
    output logic                        m_rd_nwr,
    output logic [6:0]                  m_addr,
    output logic [MAX_BYTES*8-1:0]      m_din,
    output logic [BN_W-1:0]             m_nbytes,
    input  logic [MAX_BYTES*8-1:0]      m_dout,
    input  logic                        m_done,
    input  logic                        m_error,
    output logic                        m_reset
);

    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
    localparam int DW = MAX_BYTES * 8;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_TO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_ABORT,
        S_RESPOND
    } state_t;

    state_t            state, state_n;
    logic [31:0]       timer, timer_n;
    logic [RW-1:0]     retry_cnt, retry_n;
    logic [GW-1:0]     last_grant, last_n;
    logic [GW-1:0]     grant_n;
    logic [NUM_REQ-1:0] ack_n;
    logic [DW-1:0]     data_n;
    logic [1:0]        status_n;
    logic              start_n;
    logic              mreset_n;
    logic              rd_n;
    logic [6:0]        addr_n;
    logic [DW-1:0]     din_n;
    logic [BN_W-1:0]   nb_n;

    logic              found;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     cand;
    logic [NUM_REQ-1:0] grant_oh;

    assign grant_oh = NUM_REQ'(1) << grant_idx;

    // First requester after the previous winner, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        retry_n  = retry_cnt;
        last_n   = last_grant;
        grant_n  = grant_idx;
        ack_n    = '0;
        data_n   = resp_data;
        status_n = resp_status;
        start_n  = 1'b0;
        mreset_n = 1'b0;
        rd_n     = m_rd_nwr;
        addr_n   = m_addr;
        din_n    = m_din;
        nb_n     = m_nbytes;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    grant_n = winner;
                    rd_n    = req_rd_nwr[winner];
                    addr_n  = req_addr[int'(winner)*7 +: 7];
                    din_n   = req_din[int'(winner)*DW +: DW];
                    nb_n    = req_nbytes[int'(winner)*BN_W +: BN_W];
                    retry_n = '0;
                    start_n = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                timer_n = timer + 32'd1;
                if (m_done && !m_error) begin
                    data_n   = m_dout;
                    status_n = ST_OK;
                    ack_n    = grant_oh;
                    state_n  = S_RESPOND;
                end else if (m_done && retry_cnt < RW'(MAX_RETRIES)) begin
                    retry_n = retry_cnt + RW'(1);
                    timer_n = '0;
                    state_n = S_GAP;
                end else if (m_done) begin
                    data_n   = '0;
                    status_n = ST_NACK;
                    ack_n    = grant_oh;
                    state_n  = S_RESPOND;
                end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                    timer_n  = '0;
                    mreset_n = 1'b1;
                    state_n  = S_ABORT;
                end
            end
            S_GAP: begin
                if (timer + 32'd1 >= 32'(RETRY_GAP)) begin
                    start_n = 1'b1;
                    state_n = S_ISSUE;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            S_ABORT: begin
                // Master reset is held for two cycles before reporting.
                if (timer == 32'd1) begin
                    data_n   = '0;
                    status_n = ST_TO;
                    ack_n    = grant_oh;
                    state_n  = S_RESPOND;
                end else begin
                    timer_n  = timer + 32'd1;
                    mreset_n = 1'b1;
                end
            end
            S_RESPOND: begin
                last_n  = grant_idx;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            retry_cnt   <= '0;
            last_grant  <= GW'(NUM_REQ - 1);
            grant_idx   <= '0;
            req_ack     <= '0;
            resp_data   <= '0;
            resp_status <= ST_OK;
            busy        <= 1'b0;
            m_start     <= 1'b0;
            m_reset     <= 1'b0;
            m_rd_nwr    <= 1'b0;
            m_addr      <= '0;
            m_din       <= '0;
            m_nbytes    <= '0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            retry_cnt   <= retry_n;
            last_grant  <= last_n;
            grant_idx   <= grant_n;
            req_ack     <= ack_n;
            resp_data   <= data_n;
            resp_status <= status_n;
            busy        <= (state_n != S_IDLE);
            m_start     <= start_n;
            m_reset     <= mreset_n;
            m_rd_nwr    <= rd_n;
            m_addr      <= addr_n;
            m_din       <= din_n;
            m_nbytes    <= nb_n;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: scripted i2c master model, round-robin
// reference, directed table, hand sequences and randomized traffic.
module tb_i2c_bus_arbiter;

    localparam int NR   = 2;
    localparam int MB   = 3;
    localparam int MR   = 2;
    localparam int RG   = 20;
    localparam int TO   = 100;
    localparam int BN   = 2;
    localparam int HANG = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_rd_nwr;
    logic [NR*7-1:0] req_addr;
    logic [NR*MB*8-1:0] req_din;
    logic [NR*BN-1:0] req_nbytes;
    logic [NR-1:0]   req_ack;
    logic [MB*8-1:0] resp_data;
    logic [1:0]      resp_status;
    logic            busy;
    logic [0:0]      grant_idx;
    logic            m_start;
    logic            m_rd_nwr;
    logic [6:0]      m_addr;
    logic [MB*8-1:0] m_din;
    logic [BN-1:0]   m_nbytes;
    logic [MB*8-1:0] m_dout;
    logic            m_done;
    logic            m_error;
    logic            m_reset;

    i2c_bus_arbiter #(
        .NUM_REQ(NR), .MAX_BYTES(MB), .MAX_RETRIES(MR),
        .RETRY_GAP(RG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rd_nwr(req_rd_nwr),
        .req_addr(req_addr), .req_din(req_din), .req_nbytes(req_nbytes),
        .req_ack(req_ack), .resp_data(resp_data), .resp_status(resp_status),
        .busy(busy), .grant_idx(grant_idx),
        .m_start(m_start), .m_rd_nwr(m_rd_nwr), .m_addr(m_addr),
        .m_din(m_din), .m_nbytes(m_nbytes), .m_dout(m_dout),
        .m_done(m_done), .m_error(m_error), .m_reset(m_reset)
    );

    always #5 clk = ~clk;

    // Per-requester transaction fields and master script.
    logic        rq_rd   [NR];
    logic [6:0]  rq_addr [NR];
    logic [23:0] rq_din  [NR];
    logic [1:0]  rq_nb   [NR];
    int          plan_nacks [NR];
    logic [23:0] plan_base  [NR];
    int          ack_cyc_of [NR];

    always_comb begin
        req_rd_nwr = '0;
        req_addr   = '0;
        req_din    = '0;
        req_nbytes = '0;
        for (int i = 0; i < NR; i++) begin
            req_rd_nwr[i]        = rq_rd[i];
            req_addr[i*7 +: 7]   = rq_addr[i];
            req_din[i*24 +: 24]  = rq_din[i];
            req_nbytes[i*2 +: 2] = rq_nb[i];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_acks   = 0;
    int att      = 0;
    int cur      = 0;
    int cnt      = 0;
    int model_last = NR - 1;
    int mres_cnt = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    bit pending  = 1'b0;
    logic [NR-1:0] rv_seen;
    int ack_q[$];
    int new_start_q[$];
    int last_idx, last_att;
    logic [1:0]  last_st;
    logic [23:0] last_data;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic int rr_pick(input int last, input logic [NR-1:0] rv);
        for (int k = 1; k <= NR; k++) begin
            if (rv[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Master model, arbitration reference and requester-side ack handling.
    initial begin : mon
        int a, exp_o, es, ea, nk;
        logic [23:0] ed;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rv_seen = req_valid;
            m_done  = 1'b0;
            m_error = 1'b0;
            m_dout  = 24'($urandom);
            if (reset) begin
                pending    = 1'b0;
                att        = 0;
                model_last = NR - 1;
                mres_cnt   = 0;
            end else begin
                if (m_reset) begin
                    mres_cnt++;
                    pending = 1'b0;
                end
                if (m_start) begin
                    if (att == 0) begin
                        exp_o = rr_pick(model_last, rv_seen);
                        a = -1;
                        for (int i = 0; i < NR; i++)
                            if (rv_seen[i] && rq_addr[i] == m_addr) a = i;
                        chk("grant_owner", a, exp_o);
                        cur = (a >= 0) ? a : ((exp_o >= 0) ? exp_o : 0);
                        mres_cnt = 0;
                        start_cyc = cyc;
                        new_start_q.push_back(cyc);
                    end else begin
                        chk("retry_gap", cyc - done_cyc, RG + 1);
                    end
                    chk("m_rd_nwr", m_rd_nwr, rq_rd[cur]);
                    chk("m_din", m_din, rq_din[cur]);
                    chk("m_nbytes", m_nbytes, rq_nb[cur]);
                    att++;
                    pending = 1'b1;
                    cnt = $urandom_range(0, 4);
                end else if (pending && plan_nacks[cur] != HANG) begin
                    if (cnt == 0) begin
                        m_done   = 1'b1;
                        m_error  = ((att - 1) < plan_nacks[cur]);
                        m_dout   = plan_base[cur] ^ 24'(att - 1);
                        pending  = 1'b0;
                        done_cyc = cyc;
                    end else begin
                        cnt--;
                    end
                end
                if (req_ack != '0) begin
                    a = -1;
                    for (int i = 0; i < NR; i++) if (req_ack[i]) a = i;
                    chk("ack_onehot", $countones(req_ack), 1);
                    chk("ack_idx", a, cur);
                    nk = plan_nacks[cur];
                    if (nk == HANG) begin
                        es = 2; ed = '0; ea = 1;
                        chk("timeout_latency", cyc - start_cyc, TO + 3);
                        chk("m_reset_len", mres_cnt, 2);
                    end else if (nk > MR) begin
                        es = 1; ed = '0; ea = MR + 1;
                    end else begin
                        es = 0; ed = plan_base[cur] ^ 24'(nk); ea = nk + 1;
                    end
                    chk("resp_status", resp_status, es);
                    chk("resp_data", resp_data, ed);
                    chk("attempts", att, ea);
                    last_idx  = a;
                    last_st   = resp_status;
                    last_data = resp_data;
                    last_att  = att;
                    ack_q.push_back(a);
                    n_acks++;
                    if (a >= 0) begin
                        req_valid[a]  = 1'b0;
                        ack_cyc_of[a] = cyc;
                        model_last    = a;
                    end
                    att = 0;
                    pending = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic rd, input logic [6:0] ad,
                           input logic [1:0] nb, input logic [23:0] d,
                           input int nk, input logic [23:0] b);
        rq_rd[i] = rd;
        rq_addr[i] = ad;
        rq_nb[i] = nb;
        rq_din[i] = d;
        plan_nacks[i] = nk;
        plan_base[i] = b;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int k;
        k = 0;
        while (n_acks < target && k < budget) begin
            tick();
            k++;
        end
        chk("ack_wait", n_acks >= target, 1);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_grant"}, grant_idx, 0);
        chk({nm, "_ack"}, req_ack, 0);
        chk({nm, "_all_zero"}, |{resp_data, resp_status, m_start, m_reset,
                                 m_rd_nwr, m_addr, m_din, m_nbytes}, 0);
    endtask

    typedef struct {
        int          idx;
        logic        rd;
        logic [6:0]  addr;
        logic [1:0]  nb;
        logic [23:0] din;
        int          nacks;
        logic [23:0] base;
        logic [1:0]  st;
        logic [23:0] data;
        int          starts;
    } row_t;

    row_t tbl[7];

    initial begin : main
        int raise_cyc, base_acks, n_raised, k, nk, r, a0;
        tbl[0] = '{0, 1'b1, 7'h29, 2'd2, 24'h000000, 0,    24'h003CA5, 2'b00, 24'h003CA5, 1};
        tbl[1] = '{0, 1'b1, 7'h29, 2'd2, 24'h000000, 3,    24'h111111, 2'b01, 24'h000000, 3};
        tbl[2] = '{1, 1'b1, 7'h50, 2'd3, 24'h000000, 1,    24'h123456, 2'b00, 24'h123457, 2};
        tbl[3] = '{1, 1'b0, 7'h1E, 2'd1, 24'hABCDEF, 0,    24'h0000FF, 2'b00, 24'h0000FF, 1};
        tbl[4] = '{0, 1'b0, 7'h33, 2'd3, 24'hC0FFEE, HANG, 24'h777777, 2'b10, 24'h000000, 1};
        tbl[5] = '{1, 1'b1, 7'h44, 2'd2, 24'h000000, 2,    24'h00AA00, 2'b00, 24'h00AA02, 3};
        tbl[6] = '{0, 1'b1, 7'h55, 2'd3, 24'h000000, 0,    24'hFFFFFF, 2'b00, 24'hFFFFFF, 1};
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b0, 7'(i), 2'd1, 24'h0, 0, 24'h0);
            ack_cyc_of[i] = -1;
        end
        reset = 1'b1;
        req_valid = '0;
        m_done = 1'b0;
        m_error = 1'b0;
        m_dout = '0;
        repeat (3) tick();
        chk_reset_outs("reset");
        reset = 1'b0;
        tick();

        // Both request at once from reset: 0, then 1, then 0 again.
        set_req(0, 1'b1, 7'h10, 2'd1, 24'h0, 0, 24'h000111);
        set_req(1, 1'b1, 7'h11, 2'd1, 24'h0, 0, 24'h000222);
        req_valid = 2'b11;
        raise_cyc = cyc;
        wait_acks(1, 200);
        chk("start_latency", (new_start_q.size() > 0) ? new_start_q[0] - raise_cyc : -1, 1);
        tick();
        req_valid[0] = 1'b1;
        wait_acks(3, 400);
        chk("rr_order0", (ack_q.size() > 0) ? ack_q[0] : -1, 0);
        chk("rr_order1", (ack_q.size() > 1) ? ack_q[1] : -1, 1);
        chk("rr_order2", (ack_q.size() > 2) ? ack_q[2] : -1, 0);
        tick();

        for (int t = 0; t < 7; t++) begin
            set_req(tbl[t].idx, tbl[t].rd, tbl[t].addr, tbl[t].nb, tbl[t].din,
                    tbl[t].nacks, tbl[t].base);
            req_valid[tbl[t].idx] = 1'b1;
            wait_acks(n_acks + 1, 600);
            chk("tbl_idx", last_idx, tbl[t].idx);
            chk("tbl_status", last_st, tbl[t].st);
            chk("tbl_data", last_data, tbl[t].data);
            chk("tbl_starts", last_att, tbl[t].starts);
            tick();
            chk("tbl_idle", busy, 0);
        end

        // Reset while the master is stuck mid-transaction.
        set_req(1, 1'b1, 7'h3A, 2'd2, 24'h0, HANG, 24'h0);
        a0 = n_acks;
        k = new_start_q.size();
        req_valid[1] = 1'b1;
        r = 0;
        while (new_start_q.size() == k && r < 50) begin
            tick();
            r++;
        end
        repeat (5) tick();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk_reset_outs("async_reset");
        req_valid = '0;
        tick();
        chk_reset_outs("held_reset");
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("no_ack_on_reset", n_acks, a0);
        set_req(1, 1'b1, 7'h3B, 2'd1, 24'h0, 0, 24'h0BEEF0);
        req_valid[1] = 1'b1;
        wait_acks(a0 + 1, 200);
        chk("post_reset_idx", last_idx, 1);
        chk("post_reset_data", last_data, 24'h0BEEF0);
        tick();

        // Randomized traffic against the reference model.
        base_acks = n_acks;
        n_raised = 0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && cyc > ack_cyc_of[i] && $urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 9);
                    nk = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : HANG;
                    set_req(i, 1'($urandom_range(0, 1)), {6'($urandom), 1'(i)},
                            2'($urandom_range(0, 3)), 24'($urandom), nk, 24'($urandom));
                    req_valid[i] = 1'b1;
                    n_raised++;
                end
            end
            tick();
        end
        k = 0;
        while (req_valid != '0 && k < 4000) begin
            tick();
            k++;
        end
        chk("drain_empty", req_valid, 0);
        chk("served_all", n_acks - base_acks, n_raised);
        tick();
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got no completion, required finish within bound");
        $fatal(1);
    end

endmodule
